// File: rtl/i2c_bus_condition_gen.sv
// i2c_bus_condition_gen
// Generates I2C START, REPEATED START and STOP conditions on open-drain
// SCL/SDA enables. Each phase lasts div_reg+1 clocks, and div_reg is
// captured when a command is accepted.
// Optional build macro I2C_CLK_STRETCH_EN: while the slave holds SCL low,
// phases that release SCL keep their counter at zero.
module i2c_bus_condition_gen #(
  parameter int CTR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd,
  output logic                 cmd_ready,
  input  logic [CTR_WIDTH-1:0] divisor,
  input  logic                 scl_in,
  output logic                 scl_oe,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESTART = 3'd1,
    START1  = 3'd2,
    START2  = 3'd3,
    START3  = 3'd4,
    STOP1   = 3'd5,
    STOP2   = 3'd6,
    STOP3   = 3'd7
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CTR_WIDTH-1:0] ctr;
  logic [CTR_WIDTH-1:0] ctr_next;
  logic [CTR_WIDTH-1:0] div_reg;
  logic                 accept;
  logic                 stretch_hold;

  // Pad drive levels {scl_oe, sda_oe} for each active phase.
  function automatic logic [1:0] phase_outs(input state_t s);
    case (s)
      RESTART: phase_outs = 2'b10;
      START1:  phase_outs = 2'b00;
      START2:  phase_outs = 2'b01;
      START3:  phase_outs = 2'b11;
      STOP1:   phase_outs = 2'b11;
      STOP2:   phase_outs = 2'b01;
      STOP3:   phase_outs = 2'b00;
      default: phase_outs = 2'b00;
    endcase
  endfunction

  // Successor phase in each sequence. RESTART enters the START sequence.
  function automatic state_t phase_succ(input state_t s);
    case (s)
      RESTART: phase_succ = START1;
      START1:  phase_succ = START2;
      START2:  phase_succ = START3;
      STOP1:   phase_succ = STOP2;
      STOP2:   phase_succ = STOP3;
      default: phase_succ = IDLE;
    endcase
  endfunction

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && (state == IDLE) && (cmd != 2'b00);

`ifdef I2C_CLK_STRETCH_EN
  // Only the phases that release SCL can be stretched by the slave.
  assign stretch_hold = !scl_in &&
                        ((state == START1) || (state == START2) ||
                         (state == STOP2)  || (state == STOP3));
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stretch_hold  = 1'b0;
`endif

  // Next-state and phase counter logic.
  always_comb begin
    state_next = state;
    ctr_next   = ctr;
    if (state == IDLE) begin
      if (accept) begin
        ctr_next = '0;
        case (cmd)
          2'b01:   state_next = START1;
          2'b10:   state_next = RESTART;
          default: state_next = STOP1;
        endcase
      end
    end else if (stretch_hold) begin
      ctr_next = '0;
    end else if (ctr == div_reg) begin
      ctr_next   = '0;
      state_next = phase_succ(state);
    end else begin
      ctr_next = ctr + 1'b1;
    end
  end

  // State, counter, divisor capture and registered outputs. In IDLE the
  // enables keep their last level so that the bus stays owned after START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ctr     <= '0;
      div_reg <= '0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      ctr   <= ctr_next;
      if (accept) begin
        div_reg <= divisor;
      end
      busy <= (state_next != IDLE);
      done <= (state != IDLE) && (state_next == IDLE);
      if (state_next != IDLE) begin
        {scl_oe, sda_oe} <= phase_outs(state_next);
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_condition_gen.sv
// Testbench for i2c_bus_condition_gen. Each command pushes its expected
// per-cycle trace into a queue. A monitor pops one entry per clock and
// compares it with the DUT outputs.
module tb_i2c_bus_condition_gen;

  localparam int CW = 10;

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic [1:0]    cmd;
  logic          cmd_ready;
  logic [CW-1:0] divisor;
  logic          scl_in;
  logic          scl_oe;
  logic          sda_oe;
  logic          busy;
  logic          done;

  typedef struct {
    logic [1:0] oe;
    logic       busy;
    logic       done;
    int         tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         passed = 0;
  int         cur_tag = 0;
  logic [1:0] model_oe = 2'b00;

  i2c_bus_condition_gen #(.CTR_WIDTH(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .divisor   (divisor),
    .scl_in    (scl_in),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor: one expected entry per clock, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({scl_oe, sda_oe, busy, done, cmd_ready} !==
          {mon_e.oe, mon_e.busy, mon_e.done, ~mon_e.busy}) begin
        $display("FAIL seq tag=%0d t=%0t got scl,sda,busy,done,rdy=%b%b%b%b%b want %b%b%b%b%b",
                 mon_e.tag, $time, scl_oe, sda_oe, busy, done, cmd_ready,
                 mon_e.oe[1], mon_e.oe[0], mon_e.busy, mon_e.done, ~mon_e.busy);
      end else begin
        passed++;
      end
    end
  end

  // Expected trace of one command, the done cycle and 'tail' idle cycles.
  task automatic build(input logic [1:0] c, input int d, input int extra, input int tail);
    logic [1:0] o[4];
    logic [1:0] fin;
    int n;
    int sidx;
    exp_t e;
    n = 0;
    sidx = -1;
    fin = model_oe;
    case (c)
      2'b01: begin n = 3; o[0] = 2'b00; o[1] = 2'b01; o[2] = 2'b11; fin = 2'b11; end
      2'b10: begin n = 4; o[0] = 2'b10; o[1] = 2'b00; o[2] = 2'b01; o[3] = 2'b11; fin = 2'b11; end
      2'b11: begin n = 3; o[0] = 2'b11; o[1] = 2'b01; o[2] = 2'b00; fin = 2'b00; sidx = 1; end
      default: n = 0;
    endcase
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < d + 1 + ((p == sidx) ? extra : 0); k++) begin
        e.oe = o[p]; e.busy = 1'b1; e.done = 1'b0; e.tag = cur_tag;
        exp_q.push_back(e);
      end
    end
    if (n > 0) begin
      e.oe = fin; e.busy = 1'b0; e.done = 1'b1; e.tag = cur_tag;
      exp_q.push_back(e);
      model_oe = fin;
    end
    for (int k = 0; k < tail; k++) begin
      e.oe = model_oe; e.busy = 1'b0; e.done = 1'b0; e.tag = cur_tag;
      exp_q.push_back(e);
    end
  endtask

  // Present a command for one cycle. Returns at the falling edge after acceptance.
  task automatic issue(input logic [1:0] c, input logic [CW-1:0] d, input int extra,
                       input int tail, input bit push);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd       = c;
    divisor   = d;
    if (push) build(c, int'(d), extra, tail);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain tag=%0d remaining=%0d want 0", cur_tag, exp_q.size());
      exp_q.delete();
    end else begin
      passed++;
    end
  endtask

  task automatic test_reset();
    cur_tag = 1;
    reset_n = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; divisor = '0; scl_in = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({scl_oe, sda_oe, busy, done, cmd_ready} !== 5'b00001) begin
      $display("FAIL reset_init got %b%b%b%b%b want 00001", scl_oe, sda_oe, busy, done, cmd_ready);
    end else passed++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    // RESTART, divisor 4; reset asserted 7 cycles into the sequence.
    issue(2'b10, 4, 0, 0, 0);
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_pre_busy got %b want 1", busy);
    else passed++;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({scl_oe, sda_oe, busy, done, cmd_ready} !== 5'b00001) begin
      $display("FAIL reset_async got %b%b%b%b%b want 00001", scl_oe, sda_oe, busy, done, cmd_ready);
    end else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    model_oe = 2'b00;
    repeat (2) @(negedge clk);
    checks++;
    if ({scl_oe, sda_oe, busy, done, cmd_ready} !== 5'b00001) begin
      $display("FAIL reset_release got %b%b%b%b%b want 00001", scl_oe, sda_oe, busy, done, cmd_ready);
    end else passed++;
  endtask

  task automatic test_start();
    cur_tag = 2;
    issue(2'b01, 3, 0, 3, 1);
    wait_drain(40);
  endtask

  task automatic test_nop();
    cur_tag = 3;
    issue(2'b00, 5, 0, 3, 1);
    wait_drain(10);
  endtask

  task automatic test_restart();
    cur_tag = 4;
    issue(2'b10, 0, 0, 2, 1);
    // STOP requested while busy must be ignored.
    cmd_valid = 1'b1;
    cmd       = 2'b11;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    wait_drain(20);
  endtask

  task automatic test_stop_max();
    logic [CW-1:0] all_ones;
    cur_tag = 5;
    all_ones = '1;
    issue(2'b11, all_ones, 0, 2, 1);
    divisor = 2;
    wait_drain(3 * (1 << CW) + 20);
  endtask

  task automatic test_back_to_back();
    cur_tag = 6;
    issue(2'b01, 1, 0, 0, 1);
    repeat (5) @(negedge clk);
    issue(2'b11, 1, 0, 2, 1);
    wait_drain(30);
  endtask

  task automatic test_stretch();
    int extra;
`ifdef I2C_CLK_STRETCH_EN
    extra = 5;
`else
    extra = 0;
`endif
    cur_tag = 7;
    issue(2'b11, 2, extra, 2, 1);
    repeat (3) @(negedge clk);
    scl_in = 1'b0;
    repeat (5) @(negedge clk);
    scl_in = 1'b1;
    wait_drain(40);
  endtask

  initial begin
    test_reset();
    test_start();
    test_nop();
    test_restart();
    test_stop_max();
    test_back_to_back();
    test_stretch();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
